// File: rtl/acc_drain_pkg.sv
// Shared types, saturation limits and the flat-vector column helper for the accumulator drain serializer.
package acc_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_DRAIN = DRAIN;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Upper bound on N_COLS*ACC_W that the column helper can address.
  localparam int MAX_FLAT_W  = 2048;
  localparam int FLAT_IDX_W  = $clog2(MAX_FLAT_W);

  // Returns bit bitIdx of column col from a zero-extended packed accumulator vector.
  function automatic logic colBit(input logic [MAX_FLAT_W-1:0] flat,
                                  input int                    col,
                                  input int                    bitIdx,
                                  input int                    accW);
    return flat[FLAT_IDX_W'(col * accW + bitIdx)];
  endfunction

endpackage

// File: rtl/acc_drain_serializer_if.sv
// Valid/ready beat stream from the drain serializer to the writeback/requant path.
interface acc_drain_serializer_if #(
  parameter int N_COLS = 8,
  parameter int ACC_W  = 32
);
  localparam int IDX_W = $clog2(N_COLS);

  logic                    m_valid_o;
  logic                    m_ready_i;
  logic signed [ACC_W-1:0] m_data_o;
  logic [IDX_W-1:0]        m_idx_o;
  logic                    m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_idx_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_idx_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/acc_sat_shift.sv
// Arithmetic right shift followed by a clamp to the signed int8 range, sign-extended back to ACC_W.
module acc_sat_shift
  import acc_drain_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] d_i,
  output logic signed [ACC_W-1:0] q_o
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] shifted;

  // >>> on a signed operand floors toward negative infinity.
  assign shifted = d_i >>> SHIFT;

  always_comb begin
    q_o = shifted;
    if (shifted > HI) begin
      q_o = HI;
    end else if (shifted < LO) begin
      q_o = LO;
    end
  end

endmodule

// File: rtl/acc_drain_serializer.sv
// Snapshots one PE row of accumulators and streams them out one column per valid/ready beat.
// Optional int8 requantisation of each beat is enabled with `define ACC_DRAIN_REQUANT_EN.
module acc_drain_serializer
  import acc_drain_pkg::*;
#(
  parameter int N_COLS   = 8,
  parameter int ACC_W    = 32,
  parameter int RQ_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cap_i,
  input  logic [N_COLS*ACC_W-1:0]   acc_flat_i,
  input  logic                      ovf_clr_i,
  output logic                      busy_o,
  output logic                      ovf_o,
  acc_drain_serializer_if.master    m
);

  localparam int               IDX_W    = $clog2(N_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLS - 1);

  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] shadow_q [N_COLS];

  logic                    draining;
  logic                    handshake;
  logic                    lastBeat;
  logic                    finalHs;
  logic                    capAccept;
  logic                    capDrop;
  logic signed [ACC_W-1:0] rawData;
  logic signed [ACC_W-1:0] beatData;

  assign draining  = (state_q == ST_DRAIN);
  assign handshake = draining & m.m_ready_i;
  assign lastBeat  = draining & (idx_q == LAST_IDX);
  assign finalHs   = handshake & lastBeat;
  // A capture is only taken when idle or exactly on the final beat's handshake.
  assign capAccept = cap_i & (~draining | finalHs);
  assign capDrop   = cap_i & draining & ~finalHs;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (capAccept) begin
      state_d = ST_DRAIN;
      idx_d   = '0;
    end else if (finalHs) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (handshake) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // A dropped capture outranks a clear arriving in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (capDrop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_COLS; c++) begin
        shadow_q[c] <= '0;
      end
    end else if (capAccept) begin
      for (int c = 0; c < N_COLS; c++) begin
        for (int b = 0; b < ACC_W; b++) begin
          shadow_q[c][b] <= colBit(MAX_FLAT_W'(acc_flat_i), c, b, ACC_W);
        end
      end
    end
  end

  assign rawData = draining ? shadow_q[idx_q] : '0;

`ifdef ACC_DRAIN_REQUANT_EN
  acc_sat_shift #(
    .ACC_W (ACC_W),
    .SHIFT (RQ_SHIFT)
  ) uSatShift (
    .d_i (rawData),
    .q_o (beatData)
  );
`else
  assign beatData = rawData;
`endif

  assign m.m_valid_o = draining;
  assign m.m_data_o  = beatData;
  assign m.m_idx_o   = idx_q;
  assign m.m_last_o  = lastBeat;
  assign busy_o      = draining;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_acc_drain_serializer.sv
// Directed bench for acc_drain_serializer: a queue-of-beats model checked every negedge plus pinned literal values.
module tb_acc_drain_serializer;

  localparam int N     = 8;
  localparam int W     = 32;
  localparam int RQ    = 8;
  localparam int IDX_W = $clog2(N);

`ifdef ACC_DRAIN_REQUANT_EN
  localparam longint T1_FIRST = -12;
  localparam longint T1_LAST  = 15;
  localparam longint T4_BEAT4 = 3;
`else
  localparam longint T1_FIRST = -3000;
  localparam longint T1_LAST  = 4000;
  localparam longint T4_BEAT4 = 1000;
`endif

  typedef struct {
    longint data;
    int     idx;
    bit     last;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic           capIn;
  logic           ovfClr;
  logic [N*W-1:0] accFlat;
  logic           busy;
  logic           ovf;

  int    total;
  int    bad;
  int    hsCount;
  beat_t expQ[$];
  bit    ovfExp;

  acc_drain_serializer_if #(.N_COLS(N), .ACC_W(W)) mIf ();

  acc_drain_serializer #(
    .N_COLS   (N),
    .ACC_W    (W),
    .RQ_SHIFT (RQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_i      (capIn),
    .acc_flat_i (accFlat),
    .ovf_clr_i  (ovfClr),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .m          (mIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a beat must carry for a given accumulator value.
  function automatic longint expVal(input longint v);
    longint s;
    s = v;
`ifdef ACC_DRAIN_REQUANT_EN
    s = v >>> RQ;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`endif
    return s;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, step past the next rising edge, then drop the pulse inputs.
  task automatic applyStimulus(input bit cap, input bit clr, input bit rdy);
    capIn          = cap;
    ovfClr         = clr;
    mIf.m_ready_i  = rdy;
    @(posedge clk);
    #1;
    capIn  = 1'b0;
    ovfClr = 1'b0;
  endtask

  task automatic setRamp();
    for (int c = 0; c < N; c++) accFlat[c*W +: W] = W'(c * 1000 - 3000);
  endtask

  task automatic setIndex();
    for (int c = 0; c < N; c++) accFlat[c*W +: W] = W'(c);
  endtask

  task automatic setOther();
    for (int c = 0; c < N; c++) accFlat[c*W +: W] = W'(c * 7 + 100);
  endtask

  // Model: a pending-beat queue filled on an accepted capture and popped on each handshake.
  always @(negedge clk) begin
    bit wasEmpty;
    bit hs;
    bit finalHs;
    if (!rst_n) begin
      expQ.delete();
      ovfExp = 1'b0;
      checkOutput("rst_valid", longint'(mIf.m_valid_o), 0);
      checkOutput("rst_busy",  longint'(busy), 0);
      checkOutput("rst_data",  longint'($signed(mIf.m_data_o)), 0);
      checkOutput("rst_idx",   longint'(mIf.m_idx_o), 0);
      checkOutput("rst_last",  longint'(mIf.m_last_o), 0);
      checkOutput("rst_ovf",   longint'(ovf), 0);
    end else begin
      wasEmpty = (expQ.size() == 0);
      if (!wasEmpty) begin
        checkOutput("mdl_valid", longint'(mIf.m_valid_o), 1);
        checkOutput("mdl_busy",  longint'(busy), 1);
        checkOutput("mdl_data",  longint'($signed(mIf.m_data_o)), expQ[0].data);
        checkOutput("mdl_idx",   longint'(mIf.m_idx_o), longint'(expQ[0].idx));
        checkOutput("mdl_last",  longint'(mIf.m_last_o), longint'(expQ[0].last));
      end else begin
        checkOutput("mdl_idle_valid", longint'(mIf.m_valid_o), 0);
        checkOutput("mdl_idle_busy",  longint'(busy), 0);
        checkOutput("mdl_idle_data",  longint'($signed(mIf.m_data_o)), 0);
        checkOutput("mdl_idle_idx",   longint'(mIf.m_idx_o), 0);
        checkOutput("mdl_idle_last",  longint'(mIf.m_last_o), 0);
      end
      checkOutput("mdl_ovf", longint'(ovf), longint'(ovfExp));

      hs      = !wasEmpty && (mIf.m_ready_i === 1'b1);
      finalHs = hs && (expQ.size() == 1);
      if (hs) begin
        void'(expQ.pop_front());
        hsCount++;
      end
      if (capIn && (wasEmpty || finalHs)) begin
        for (int c = 0; c < N; c++) begin
          beat_t b;
          b.data = expVal(longint'($signed(accFlat[c*W +: W])));
          b.idx  = c;
          b.last = (c == N - 1);
          expQ.push_back(b);
        end
      end
      if (capIn && !(wasEmpty || finalHs)) begin
        ovfExp = 1'b1;
      end else if (ovfClr) begin
        ovfExp = 1'b0;
      end
    end
  end

  initial begin
    int hs0;
    total         = 0;
    bad           = 0;
    hsCount       = 0;
    ovfExp        = 1'b0;
    rst_n         = 1'b0;
    capIn         = 1'b0;
    ovfClr        = 1'b0;
    mIf.m_ready_i = 1'b0;
    accFlat       = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("idle_ignores_ready", longint'(mIf.m_valid_o), 0);

    $display("[TB] single snapshot, full-rate drain");
    setRamp();
    hs0 = hsCount;
    applyStimulus(1, 0, 1);
    checkOutput("t1_first_valid", longint'(mIf.m_valid_o), 1);
    checkOutput("t1_first_idx",   longint'(mIf.m_idx_o), 0);
    checkOutput("t1_first_data",  longint'($signed(mIf.m_data_o)), T1_FIRST);
    checkOutput("t1_first_last",  longint'(mIf.m_last_o), 0);
    repeat (7) applyStimulus(0, 0, 1);
    checkOutput("t1_last_idx",  longint'(mIf.m_idx_o), 7);
    checkOutput("t1_last_flag", longint'(mIf.m_last_o), 1);
    checkOutput("t1_last_data", longint'($signed(mIf.m_data_o)), T1_LAST);
    applyStimulus(0, 0, 1);
    checkOutput("t1_busy_drop", longint'(busy), 0);
    checkOutput("t1_beats", longint'(hsCount - hs0), 8);

    $display("[TB] backpressure on beat 3");
    hs0 = hsCount;
    applyStimulus(1, 0, 1);
    repeat (3) applyStimulus(0, 0, 1);
    mIf.m_ready_i = 1'b0;
    checkOutput("t2_hold_idx",  longint'(mIf.m_idx_o), 3);
    checkOutput("t2_hold_data", longint'($signed(mIf.m_data_o)), 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput("t2_hold_idx",   longint'(mIf.m_idx_o), 3);
      checkOutput("t2_hold_data",  longint'($signed(mIf.m_data_o)), 0);
      checkOutput("t2_hold_valid", longint'(mIf.m_valid_o), 1);
    end
    applyStimulus(0, 0, 1);
    checkOutput("t2_resume_idx", longint'(mIf.m_idx_o), 4);
    repeat (4) applyStimulus(0, 0, 1);
    checkOutput("t2_beats", longint'(hsCount - hs0), 8);
    checkOutput("t2_idle", longint'(busy), 0);

    $display("[TB] gapless back-to-back capture");
    applyStimulus(1, 0, 1);
    repeat (7) applyStimulus(0, 0, 1);
    setIndex();
    applyStimulus(1, 0, 1);
    checkOutput("t3_valid", longint'(mIf.m_valid_o), 1);
    checkOutput("t3_idx",   longint'(mIf.m_idx_o), 0);
    checkOutput("t3_data",  longint'($signed(mIf.m_data_o)), 0);
    checkOutput("t3_ovf",   longint'(ovf), 0);
    applyStimulus(0, 0, 1);
    checkOutput("t3_idx1",  longint'(mIf.m_idx_o), 1);
    repeat (7) applyStimulus(0, 0, 1);

    $display("[TB] dropped capture and sticky overflow");
    setRamp();
    applyStimulus(1, 0, 1);
    repeat (2) applyStimulus(0, 0, 1);
    checkOutput("t4_at_idx2", longint'(mIf.m_idx_o), 2);
    setOther();
    applyStimulus(1, 0, 1);
    checkOutput("t4_ovf_set", longint'(ovf), 1);
    checkOutput("t4_keep_data3", longint'($signed(mIf.m_data_o)), 0);
    applyStimulus(0, 0, 1);
    checkOutput("t4_keep_data4", longint'($signed(mIf.m_data_o)), T4_BEAT4);
    applyStimulus(1, 1, 1);
    checkOutput("t4_set_wins", longint'(ovf), 1);
    applyStimulus(0, 1, 1);
    checkOutput("t4_ovf_clr", longint'(ovf), 0);
    repeat (2) applyStimulus(0, 0, 1);

    $display("[TB] reset in the middle of a drain");
    setRamp();
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("t5_ovf_before", longint'(ovf), 1);
    repeat (4) applyStimulus(0, 0, 1);
    checkOutput("t5_at_idx5", longint'(mIf.m_idx_o), 5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", longint'(mIf.m_valid_o), 0);
    checkOutput("t5_async_busy",  longint'(busy), 0);
    checkOutput("t5_async_idx",   longint'(mIf.m_idx_o), 0);
    checkOutput("t5_async_data",  longint'($signed(mIf.m_data_o)), 0);
    checkOutput("t5_async_ovf",   longint'(ovf), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    setIndex();
    applyStimulus(1, 0, 1);
    checkOutput("t5_restart_idx",   longint'(mIf.m_idx_o), 0);
    checkOutput("t5_restart_valid", longint'(mIf.m_valid_o), 1);
    repeat (8) applyStimulus(0, 0, 1);

`ifdef ACC_DRAIN_REQUANT_EN
    $display("[TB] requant saturation");
    accFlat = '0;
    accFlat[0*W +: W] = W'(70000);
    accFlat[1*W +: W] = W'(-70000);
    accFlat[2*W +: W] = W'(1000);
    accFlat[3*W +: W] = W'(-1);
    applyStimulus(1, 0, 1);
    checkOutput("t6_pos_sat", longint'($signed(mIf.m_data_o)), 127);
    applyStimulus(0, 0, 1);
    checkOutput("t6_neg_sat", longint'($signed(mIf.m_data_o)), -128);
    applyStimulus(0, 0, 1);
    checkOutput("t6_in_range", longint'($signed(mIf.m_data_o)), 3);
    applyStimulus(0, 0, 1);
    checkOutput("t6_floor", longint'($signed(mIf.m_data_o)), -1);
    repeat (5) applyStimulus(0, 0, 1);
`endif

    repeat (3) applyStimulus(0, 0, 1);
    checkOutput("end_idle", longint'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
